// File: rtl/nano6502_pkg.sv
// Shared register map, bit positions and reset values for the nano6502 UART
// receive buffer.
package nano6502_pkg;

  localparam logic [1:0] RXB_DATA   = 2'd0;
  localparam logic [1:0] RXB_STATUS = 2'd1;
  localparam logic [1:0] RXB_COUNT  = 2'd2;
  localparam logic [1:0] RXB_CTRL   = 2'd3;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_IRQ       = 3;

  localparam int CTRL_RX_IRQ_EN  = 0;
  localparam int CTRL_OVR_IRQ_EN = 1;
  localparam int CTRL_RSVD       = 2;
  localparam int CTRL_THR_LSB    = 3;

  localparam logic [7:0] CTRL_RESET = 8'h08;

  // A programmed threshold of zero behaves exactly like a threshold of one.
  function automatic logic [4:0] thr_eff(input logic [4:0] thr);
    return (thr == 5'd0) ? 5'd1 : thr;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a pop on empty is ignored and a push on full
// only succeeds when a real pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, wr_d;
  logic [DEPTH_LOG2-1:0] rd_q, rd_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == DEPTH_CNT);
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = data_i;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    head_o  = empty_o ? '0 : mem_q[rd_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes stale entries.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffered UART receive front end: FIFO of received bytes, a 4-register CPU
// window (DATA/STATUS/COUNT/CTRL) and a registered active-low interrupt.
module uart_rx_buffer
  import nano6502_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       cs_i,
  input  logic       R_W_n,
  input  logic [1:0] reg_addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq_n_o
);

  localparam int CW = DEPTH_LOG2 + 1;

  // Handshake: rx_valid_i is a one-cycle strobe with no back-pressure; a CPU
  // read of DATA (cs_i & R_W_n) pops at the edge ending that bus cycle.
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          pop, st_wr, ctrl_wr, flush, ovr_clr, ovr_set;
  logic [7:0]    count_ext, thr_ext;
  logic          irq_cond;

  logic       overrun_q, overrun_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic       irq_n_q, irq_n_d;

  sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (8)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (rx_valid_i),
    .pop_i  (pop),
    .flush_i(flush),
    .data_i (rx_data_i),
    .head_o (head),
    .count_o(count),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    pop     = cs_i & R_W_n & (reg_addr_i == RXB_DATA);
    st_wr   = cs_i & ~R_W_n & (reg_addr_i == RXB_STATUS);
    ctrl_wr = cs_i & ~R_W_n & (reg_addr_i == RXB_CTRL);
    flush   = st_wr & data_i[ST_NOT_EMPTY];
    ovr_clr = st_wr & data_i[ST_OVERRUN];
    // A byte is lost only if the FIFO stays full this cycle and no flush
    // discards it anyway.
    ovr_set = rx_valid_i & full & ~(pop & ~empty) & ~flush;

    overrun_d = overrun_q;
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end

    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d = data_i;
      ctrl_d[CTRL_RSVD] = 1'b0;
    end

    count_ext = {{(8 - CW){1'b0}}, count};
    thr_ext   = {3'b000, thr_eff(ctrl_q[7:CTRL_THR_LSB])};
    irq_cond  = (ctrl_q[CTRL_RX_IRQ_EN] & (count_ext >= thr_ext)) |
                (ctrl_q[CTRL_OVR_IRQ_EN] & overrun_q);
    irq_n_d   = ~irq_cond;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
      ctrl_q    <= CTRL_RESET;
      irq_n_q   <= 1'b1;
    end else begin
      overrun_q <= overrun_d;
      ctrl_q    <= ctrl_d;
      irq_n_q   <= irq_n_d;
    end
  end

  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      RXB_DATA: data_o = head;
      RXB_STATUS: begin
        data_o[ST_NOT_EMPTY] = ~empty;
        data_o[ST_FULL]      = full;
        data_o[ST_OVERRUN]   = overrun_q;
        data_o[ST_IRQ]       = ~irq_n_q;
      end
      RXB_COUNT: data_o = count_ext;
      default:   data_o = ctrl_q;
    endcase
  end

  assign irq_n_o = irq_n_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with a byte scoreboard for DATA reads; a
// second instance with an 8-entry FIFO covers the small-depth overflow case.
module tb_uart_rx_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cs = 1'b0;
  logic       rw_n = 1'b1;
  logic [1:0] reg_addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] data_o, data_o3;
  logic       irq_n, irq_n3;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_rx_buffer #(.DEPTH_LOG2(4)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .cs_i(cs), .R_W_n(rw_n), .reg_addr_i(reg_addr), .data_i(wdata),
    .data_o(data_o), .irq_n_o(irq_n)
  );

  uart_rx_buffer #(.DEPTH_LOG2(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .cs_i(cs), .R_W_n(rw_n), .reg_addr_i(reg_addr), .data_i(wdata),
    .data_o(data_o3), .irq_n_o(irq_n3)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input logic [1:0] a, input logic [7:0] exp, input string tag);
    cs = 1'b0;
    reg_addr = a;
    #1;
    check8(tag, data_o, exp);
  endtask

  task automatic check_reg3(input logic [1:0] a, input logic [7:0] exp, input string tag);
    cs = 1'b0;
    reg_addr = a;
    #1;
    check8(tag, data_o3, exp);
  endtask

  task automatic check_irq(input logic exp, input string tag);
    check8(tag, {7'b0, irq_n}, {7'b0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [7:0] e;
    cs = 1'b1;
    rw_n = 1'b1;
    reg_addr = 2'd0;
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    check8(tag, data_o, e);
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic push_read(input logic [7:0] b, input string tag);
    logic [7:0] e;
    rx_valid = 1'b1;
    rx_data = b;
    cs = 1'b1;
    rw_n = 1'b1;
    reg_addr = 2'd0;
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    check8(tag, data_o, e);
    exp_q.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
    cs = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] v, input logic with_push,
                           input logic [7:0] b);
    cs = 1'b1;
    rw_n = 1'b0;
    reg_addr = a;
    wdata = v;
    rx_valid = with_push;
    rx_data = b;
    if (a == 2'd1 && v[0]) exp_q.delete();
    else if (with_push && exp_q.size() < DEPTH) exp_q.push_back(b);
    @(negedge clk);
    cs = 1'b0;
    rw_n = 1'b1;
    rx_valid = 1'b0;
  endtask

  initial begin
    // reset
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reg(2'd2, 8'h00, "rst_count");
    check_reg(2'd1, 8'h00, "rst_status");
    check_reg(2'd3, 8'h08, "rst_ctrl");
    check_reg(2'd0, 8'h00, "rst_data");
    check_irq(1'b1, "rst_irq");
    check8("rst_irq3", {7'b0, irq_n3}, 8'h01);

    // basic three bytes
    push(8'h41); push(8'h42); push(8'h43);
    check_reg(2'd2, 8'h03, "t1_count");
    check_reg(2'd1, 8'h01, "t1_status");
    for (int i = 0; i < 3; i++) read_data("t1_data");
    check_reg(2'd2, 8'h00, "t1_count_empty");
    read_data("t1_data_empty");

    // overflow of the 16-entry FIFO
    for (int i = 0; i < 17; i++) push(8'(i));
    check_reg(2'd2, 8'h10, "t2_count");
    check_reg(2'd1, 8'h07, "t2_status");
    for (int i = 0; i < 16; i++) read_data("t2_drain");
    check_reg(2'd1, 8'h04, "t2_ovr_sticky");
    write_reg(2'd1, 8'h04, 1'b0, 8'h00);
    check_reg(2'd1, 8'h00, "t2_ovr_clear");

    // push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    push_read(8'h55, "t3_old_head");
    check_reg(2'd2, 8'h10, "t3_count");
    check_reg(2'd1, 8'h03, "t3_status");
    for (int i = 0; i < 15; i++) read_data("t3_drain");
    check_reg(2'd0, 8'h55, "t3_last_is_55");
    read_data("t3_drain_last");
    check_reg(2'd2, 8'h00, "t3_count_empty");

    // push and pop in the same cycle while empty
    push_read(8'h33, "t3b_empty_data");
    check_reg(2'd2, 8'h01, "t3b_count");
    read_data("t3b_data");

    // rx threshold interrupt
    write_reg(2'd3, 8'h21, 1'b0, 8'h00);
    check_reg(2'd3, 8'h21, "t4_ctrl");
    push(8'h01); push(8'h02); push(8'h03);
    @(negedge clk);
    check_irq(1'b1, "t4_irq_below_thr");
    push(8'h04);
    check_irq(1'b1, "t4_irq_n1");
    @(negedge clk);
    check_irq(1'b0, "t4_irq_n2");
    check_reg(2'd1, 8'h09, "t4_status_pending");
    read_data("t4_pop");
    check_irq(1'b0, "t4_irq_pop_n1");
    @(negedge clk);
    check_irq(1'b1, "t4_irq_pop_n2");
    for (int i = 0; i < 3; i++) read_data("t4_drain");
    write_reg(2'd3, 8'h04, 1'b0, 8'h00);
    check_reg(2'd3, 8'h00, "t4_ctrl_rsvd");
    // threshold 0 acts as 1
    write_reg(2'd3, 8'h01, 1'b0, 8'h00);
    push(8'h99);
    @(negedge clk);
    check_irq(1'b0, "t4_thr0_irq");
    read_data("t4_thr0_data");
    @(negedge clk);
    check_irq(1'b1, "t4_thr0_irq_clear");
    write_reg(2'd3, 8'h00, 1'b0, 8'h00);

    // overrun interrupt on the 8-entry instance
    do_reset();
    write_reg(2'd3, 8'h02, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) push(8'hC0 + 8'(i));
    @(negedge clk);
    check8("t5_irq3_ovr", {7'b0, irq_n3}, 8'h00);
    check_irq(1'b1, "t5_irq16_no_ovr");
    check_reg3(2'd1, 8'h0F, "t5_status3");
    write_reg(2'd1, 8'h04, 1'b0, 8'h00);
    @(negedge clk);
    check8("t5_irq3_clear", {7'b0, irq_n3}, 8'h01);
    write_reg(2'd1, 8'h01, 1'b1, 8'hAA);
    check_reg(2'd2, 8'h00, "t5_flush_count");
    check_reg3(2'd2, 8'h00, "t5_flush_count3");
    check_reg3(2'd1, 8'h00, "t5_flush_status3");
    read_data("t5_flush_data");

    // reset mid-stream
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    do_reset();
    check_reg(2'd2, 8'h00, "t6_count");
    check_reg(2'd1, 8'h00, "t6_status");
    check_reg(2'd3, 8'h08, "t6_ctrl");
    check_irq(1'b1, "t6_irq");
    push(8'h7E);
    read_data("t6_first_after_rst");
    check8("t6_queue_empty", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
